// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store read-modify-write controller.
// Size encodings, FSM state enum and the request legality check.
package lsu_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Illegal size, or a half/word whose byte offset breaks natural alignment.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'b00);
            SZ_X:    bad = 1'b1;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Little-endian lane steering: merges sub-word store data into the read word
// and extracts/extends load data from it. Purely combinational.
module lsu_lane_merge
    import lsu_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic              is_unsigned,
    output logic [DATA_W-1:0] store_word,
    output logic [DATA_W-1:0] load_word
);

    logic [4:0]        sh_amt;
    logic [DATA_W-1:0] lane_mask;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        sh_amt    = 5'd0;
        lane_mask = '1;
        case (size)
            SZ_B: begin
                sh_amt    = {offset, 3'b000};
                lane_mask = 32'h0000_00FF << sh_amt;
            end
            SZ_H: begin
                sh_amt    = {offset[1], 4'b0000};
                lane_mask = 32'h0000_FFFF << sh_amt;
            end
            default: begin
                sh_amt    = 5'd0;
                lane_mask = '1;
            end
        endcase
    end

    assign store_word = (rdata & ~lane_mask) | ((wdata << sh_amt) & lane_mask);
    assign shifted    = rdata >> sh_amt;

    always_comb begin
        load_word = rdata;
        case (size)
            SZ_B:    load_word = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
            SZ_H:    load_word = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
            default: load_word = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_rmw.sv
// Load/store controller in front of a word-write-only data RAM. Sub-word stores
// run as read-modify-write; loads return extended data in a one-cycle pulse.
// Handshake: a request transfers on a rising edge with req_valid && req_ready;
// req_ready is high only in IDLE, and the response pulse has no backpressure.
module lsu_rmw
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              ram_we,
    output logic              ram_prt_en0,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_re,
    output logic              ram_prt_en1,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output lsu_state_e        dbg_state
);

    lsu_state_e state_q, state_d;

    logic              we_q, uns_q, err_q;
    logic [1:0]        size_q;
    logic [ADDR_W+1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic [DATA_W-1:0] store_word, load_word;
    logic              accept;

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= 2'b00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= req_we;
                uns_q   <= req_unsigned;
                err_q   <= req_bad(req_size, req_addr[1:0]);
                size_q  <= req_size;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            // RAM read data is only defined while the read port is enabled.
            if (state_q == ST_READ) begin
                rdata_q <= ram_rdata;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    if (req_bad(req_size, req_addr[1:0])) begin
                        state_d = ST_RESP;
                    end else if (req_we && (req_size == SZ_W)) begin
                        state_d = ST_WRITE;
                    end else begin
                        state_d = ST_READ;
                    end
                end
            end
            ST_READ:  state_d = we_q ? ST_WRITE : ST_RESP;
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    lsu_lane_merge u_lane_merge (
        .rdata       (rdata_q),
        .wdata       (wdata_q),
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_unsigned (uns_q),
        .store_word  (store_word),
        .load_word   (load_word)
    );

    // Enables depend on the state register alone, never on live request inputs.
    assign ram_we      = (state_q == ST_WRITE);
    assign ram_prt_en0 = (state_q == ST_WRITE);
    assign ram_re      = (state_q == ST_READ);
    assign ram_prt_en1 = (state_q == ST_READ);
    assign ram_waddr   = addr_q[ADDR_W+1:2];
    assign ram_raddr   = addr_q[ADDR_W+1:2];
    assign ram_wdata   = store_word;

    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = (state_q == ST_RESP) && err_q;
    assign rsp_rdata = ((state_q == ST_RESP) && !we_q && !err_q) ? load_word : '0;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw with a behavioural word RAM; checks latency,
// load data, error flags and RAM port activity per request.
module tb_lsu_rmw;
    import lsu_pkg::*;

    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [ADDR_W+1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic              ram_we, ram_prt_en0, ram_re, ram_prt_en1;
    logic [ADDR_W-1:0] ram_waddr, ram_raddr;
    logic [31:0]       ram_wdata, ram_rdata;
    lsu_state_e        dbg_state;

    logic [31:0] mem [0:(1<<ADDR_W)-1];
    int          we_cnt = 0;
    int          passed = 0;
    int          total  = 0;

    always #5 clk = ~clk;

    // Behavioural RAM: word write at the clock edge, combinational read.
    always @(posedge clk) begin
        if (ram_we && ram_prt_en0) begin
            mem[ram_waddr] <= ram_wdata;
            we_cnt         <= we_cnt + 1;
        end
    end
    assign ram_rdata = (ram_re && ram_prt_en1) ? mem[ram_raddr] : 32'hBAD0_BAD0;

    lsu_rmw #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .ram_we       (ram_we),
        .ram_prt_en0  (ram_prt_en0),
        .ram_waddr    (ram_waddr),
        .ram_wdata    (ram_wdata),
        .ram_re       (ram_re),
        .ram_prt_en1  (ram_prt_en1),
        .ram_raddr    (ram_raddr),
        .ram_rdata    (ram_rdata),
        .dbg_state    (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one request from IDLE and follow it to its response (bounded wait).
    task automatic run_req(input string tag, input logic we, input logic [1:0] size,
                           input logic uns, input logic [6:0] addr, input logic [31:0] wdata,
                           input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
        int   lat;
        logic saw_re, saw_we, saw_ready;
        @(negedge clk);
        chk({tag, " idle_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, " idle_no_rsp"}, {31'd0, rsp_valid}, 32'd0);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 7'h55;
        req_wdata = 32'h5A5A_5A5A;
        lat       = 0;
        saw_re    = 1'b0;
        saw_we    = 1'b0;
        saw_ready = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            saw_re    = saw_re | ram_re | ram_prt_en1;
            saw_we    = saw_we | ram_we | ram_prt_en0;
            saw_ready = saw_ready | req_ready;
            if (rsp_valid) begin
                lat = c;
                break;
            end
        end
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        chk({tag, " rdata"}, rsp_rdata, exp_rdata);
        chk({tag, " ram_read"}, {31'd0, saw_re},
            {31'd0, !exp_err && !(we && size == SZ_W)});
        chk({tag, " ram_write"}, {31'd0, saw_we}, {31'd0, we && !exp_err});
        chk({tag, " busy"}, {31'd0, saw_ready}, 32'd0);
    endtask

    initial begin
        int we_before;
        int rsp_seen;

        // Reset state
        #2;
        chk("rst ready", {31'd0, req_ready}, 32'd1);
        chk("rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst rsp_rdata", rsp_rdata, 32'd0);
        chk("rst enables", {28'd0, ram_we, ram_prt_en0, ram_re, ram_prt_en1}, 32'd0);
        chk("rst waddr", {27'd0, ram_waddr}, 32'd0);
        chk("rst raddr", {27'd0, ram_raddr}, 32'd0);
        chk("rst wdata", ram_wdata, 32'd0);
        chk("rst state", {30'd0, dbg_state}, {30'd0, ST_IDLE});
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Word store / load round trip
        run_req("sw 14", 1'b1, SZ_W, 1'b0, 7'h14, 32'hDEAD_BEEF, 2, 1'b0, 32'h0);
        run_req("lw 14", 1'b0, SZ_W, 1'b0, 7'h14, 32'h0, 2, 1'b0, 32'hDEAD_BEEF);

        // Byte RMW into lane 3
        run_req("sw base", 1'b1, SZ_W, 1'b0, 7'h14, 32'h1122_3344, 2, 1'b0, 32'h0);
        run_req("sb 17", 1'b1, SZ_B, 1'b0, 7'h17, 32'hFFFF_FFAA, 3, 1'b0, 32'h0);
        run_req("lw rmw", 1'b0, SZ_W, 1'b0, 7'h14, 32'h0, 2, 1'b0, 32'hAA22_3344);

        // Extension on loads
        run_req("sw 20", 1'b1, SZ_W, 1'b0, 7'h20, 32'h8000_0000, 2, 1'b0, 32'h0);
        run_req("lb 23", 1'b0, SZ_B, 1'b0, 7'h23, 32'h0, 2, 1'b0, 32'hFFFF_FF80);
        run_req("lbu 23", 1'b0, SZ_B, 1'b1, 7'h23, 32'h0, 2, 1'b0, 32'h0000_0080);
        run_req("sw 24", 1'b1, SZ_W, 1'b0, 7'h24, 32'h8001_0000, 2, 1'b0, 32'h0);
        run_req("lhu 26", 1'b0, SZ_H, 1'b1, 7'h26, 32'h0, 2, 1'b0, 32'h0000_8001);
        run_req("lh 26", 1'b0, SZ_H, 1'b0, 7'h26, 32'h0, 2, 1'b0, 32'hFFFF_8001);
        run_req("lh 24", 1'b0, SZ_H, 1'b0, 7'h24, 32'h0, 2, 1'b0, 32'h0000_0000);

        // Top word index, half and byte RMW
        run_req("sw 7c", 1'b1, SZ_W, 1'b0, 7'h7C, 32'h1234_5678, 2, 1'b0, 32'h0);
        run_req("sh 7e", 1'b1, SZ_H, 1'b0, 7'h7E, 32'hFFFF_BEEF, 3, 1'b0, 32'h0);
        run_req("lw 7c a", 1'b0, SZ_W, 1'b0, 7'h7C, 32'h0, 2, 1'b0, 32'hBEEF_5678);
        run_req("sb 7d", 1'b1, SZ_B, 1'b0, 7'h7D, 32'h0000_00CC, 3, 1'b0, 32'h0);
        run_req("lw 7c b", 1'b0, SZ_W, 1'b0, 7'h7C, 32'h0, 2, 1'b0, 32'hBEEF_CC78);
        run_req("lb 7d", 1'b0, SZ_B, 1'b0, 7'h7D, 32'h0, 2, 1'b0, 32'hFFFF_FFCC);
        chk("mem top", mem[31], 32'hBEEF_CC78);

        // Errors: no RAM access, response one cycle after accept
        we_before = we_cnt;
        run_req("lw 06 err", 1'b0, SZ_W, 1'b0, 7'h06, 32'h0, 1, 1'b1, 32'h0);
        run_req("sx 10 err", 1'b1, SZ_X, 1'b0, 7'h10, 32'hFFFF_FFFF, 1, 1'b1, 32'h0);
        run_req("lh 01 err", 1'b0, SZ_H, 1'b0, 7'h01, 32'h0, 1, 1'b1, 32'h0);
        run_req("sw 02 err", 1'b1, SZ_W, 1'b0, 7'h02, 32'h1234_5678, 1, 1'b1, 32'h0);
        chk("err no writes", we_cnt, we_before);

        // Reset during READ of a sub-word store
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = SZ_B;
        req_addr  = 7'h15;
        req_wdata = 32'h0000_0055;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("mid state read", {30'd0, dbg_state}, {30'd0, ST_READ});
        we_before = we_cnt;
        rst = 1'b1;
        #1;
        chk("mid rst ready", {31'd0, req_ready}, 32'd1);
        chk("mid rst rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid rst enables", {28'd0, ram_we, ram_prt_en0, ram_re, ram_prt_en1}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rsp_seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) rsp_seen = rsp_seen + 1;
        end
        chk("mid rst no rsp", rsp_seen, 0);
        chk("mid rst no write", we_cnt, we_before);
        run_req("lw after rst", 1'b0, SZ_W, 1'b0, 7'h14, 32'h0, 2, 1'b0, 32'hAA22_3344);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/lsu_rmw.md
# lsu_rmw

Load/store controller sitting directly upstream of the core's 32-bit data RAM. Accepts byte/halfword/word load and store requests from the execute stage and drives the RAM's single write port and single read port. Because the RAM only writes whole words, sub-word stores are done as read-modify-write. Returns sign- or zero-extended load data through a one-cycle response pulse.

## Interface
Parameters:
- ADDR_W, 5, RAM word-address width; byte address is ADDR_W+2 bits.
- DATA_W, 32, RAM word width; fixed at 32.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted when req_valid && req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W+2  byte address; [ADDR_W+1:2] = word index, [1:0] = byte offset.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or illegal-size request; valid with rsp_valid.
- ram_we, ram_prt_en0  out  1 each  write-port enables, both high only in WRITE.
- ram_waddr  out  ADDR_W  write word address.
- ram_wdata  out  32  merged write word.
- ram_re, ram_prt_en1  out  1 each  read-port enables, both high only in READ.
- ram_raddr  out  ADDR_W  read word address.
- ram_rdata  in  32  combinational RAM read data; high-Z when not enabled, sampled only in READ.

## Operation
- Acceptance latches we, size, unsigned, addr and wdata into request registers. Inputs are ignored outside IDLE.
- Error check at acceptance:
  - size = 11 is illegal.
  - Half with addr[0] = 1 is misaligned.
  - Word with addr[1:0] != 0 is misaligned.
  - Either case goes to RESP with rsp_err = 1 and no RAM access.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE -> RESP on error.
  - IDLE -> WRITE for a word store.
  - IDLE -> READ for a load or a sub-word store.
  - READ -> RESP for a load.
  - READ -> WRITE for a sub-word store.
  - WRITE -> RESP.
  - RESP -> IDLE.
- READ: ram_raddr = word index. ram_rdata is captured into rdata_q at the edge leaving READ.
- Lane select, little-endian: byte lane = addr[1:0]; half lane = addr[1] (0 = bits 15:0, 1 = bits 31:16).
- Load: extract the lane from rdata_q, then sign- or zero-extend to 32 bits per req_unsigned. Word loads pass through unchanged.
- Sub-word store: ram_wdata = rdata_q with only the selected lane replaced by wdata[7:0] or wdata[15:0]. Word store: ram_wdata = wdata.
- RESP: rsp_valid = 1 for exactly one cycle. There is no response backpressure; the consumer must take it.
- RAM enable outputs are decoded from the state register only, so they are glitch-free relative to request inputs.

## Timing
- Reset values:
  - state = IDLE, so req_ready = 1.
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0.
  - All ram_* enables = 0; ram_waddr, ram_raddr and ram_wdata = 0.
  - All request registers and rdata_q = 0.
- Latency from the accept edge T, counted as the cycle in which rsp_valid is high:
  - Error: T+1.
  - Load: T+2.
  - Word store: T+2.
  - Sub-word store: T+3.
- The RAM write lands at the rising edge that ends WRITE. A load accepted in the RESP+1 cycle (back in IDLE) observes it.
- Throughput is one request per 3 cycles minimum (word store, load) and 4 cycles for sub-word stores. req_ready is low from the cycle after acceptance until IDLE is re-entered.
- Reset mid-operation: all outputs drop immediately (asynchronous). If reset is asserted before the edge that ends WRITE, no write occurs. The pending request is discarded with no response.
- Byte offset 3 and half offset 2 are legal. The top word index (2^ADDR_W - 1) is legal; there is no wrap beyond it.

## Structure
- lsu_pkg: size encodings (SZ_B, SZ_H, SZ_W), FSM state enum, DATA_W constant.
- Sub-module lsu_lane_merge: purely combinational. Inputs are rdata_q, wdata, size, offset and unsigned. Outputs are the merged store word and the extended load word. It is instantiated once.
- Top-level module: FSM, request registers, rdata_q, output decode.

## Test plan
- Reset: rst pulsed mid-stream -> req_ready = 1, rsp_valid = 0, all ram enables 0 while rst = 1.
- Word store 0xDEADBEEF to byte address 0x14, then word load from 0x14 -> store response at T+2; rsp_rdata = 0xDEADBEEF at T+2 of the load.
- Byte store 0xAA to 0x17 over word 0x11223344, then word load -> RAM word 0xAA223344, store response at T+3.
- Signed byte load from offset 3 of 0x80000000 -> 0xFFFFFF80. Unsigned half load from offset 2 of 0x8001_0000 -> 0x00008001.
- Misaligned word load at 0x06 and size = 11 store -> rsp_err = 1 at T+1, ram_re and ram_we never asserted.
- Reset asserted during READ of a sub-word store -> no RAM write, no rsp_valid, next request serviced normally.
